pipelined_cla_adder: RTL
========================

# pipelined_cla_adder

Parametrised, pipelined carry-look-ahead adder/subtractor. It is the successor to the team's fixed-width combinational CLA chain. WIDTH is split into STAGES = WIDTH/BLOCK slices; each slice is resolved in one registered stage by 4-bit CLA groups, and the carry is registered between stages. It accepts one operation per cycle under valid/ready flow control and returns the aligned sum with carry, signed-overflow and zero flags.

## Interface
- WIDTH, 64: operand/sum width; must be a multiple of BLOCK.
- BLOCK, 16: bits resolved per pipeline stage; must be a multiple of 4.
- TAG_W, 4: width of the user tag carried alongside each operation.
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  pipeline can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in, used for add only.
- op_sub  input  1  0 = add, 1 = subtract (A - B).
- tag_in  input  TAG_W  user tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1. For subtract this is 1 when there is no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.
- tag_out  output  TAG_W  tag of the presented result.

## Operation
- Effective operands:
  - Add: A + B + cin.
  - Subtract: A + ~B + 1. cin is ignored.
  - The B inversion and carry select happen at input capture.
- Slice k covers bits [k*BLOCK +: BLOCK].
- Stage k does the following:
  - computes slice k from registered operand bits and the registered carry out of stage k-1 (stage 0 uses the captured carry-in);
  - inside the slice, computes p = a^b and g = a&b per bit, 4-bit group look-ahead carries, and ripples between groups;
  - registers the slice sum and slice carry;
  - forwards unconsumed operand slices and already-resolved sum slices, so every result bit leaves aligned.
- Each stage has a valid bit, and bubbles propagate as invalid stages.
- Flags are derived at the final stage from the full result:
  - ovf = (A[W-1] == B_eff[W-1]) && (sum[W-1] != A[W-1]), where B_eff is B or ~B;
  - zero is 1 when all sum bits are 0;
  - cout is the carry out of the final slice.
- Flow control:
  - The pipeline advances as a whole (global enable): adv = !out_valid || out_ready.
  - in_ready = adv. An operation is accepted when in_valid && in_ready at a rising edge.
  - When adv = 0, every stage register holds, including the output registers, and sum/flags/tag_out stay stable.
  - If in_valid = 0 on an advancing cycle, an invalid bubble enters stage 0.
- Reset:
  - All stage valid bits clear.
  - out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0, tag_out = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight operations; nothing is emitted for them.
- Parameter violations (WIDTH % BLOCK != 0, or BLOCK % 4 != 0) are elaboration errors.

## Timing
- Latency: STAGES cycles. An operation accepted at edge N is presented with out_valid = 1 after edge N+STAGES-1 if there are no stalls. The default parameters give 4 cycles.
- Throughput: one operation per cycle while out_ready = 1.
- Stall: when out_valid && !out_ready, in_ready drops combinationally in the same cycle. No accept and no output change occur until out_ready returns. The presented result is taken on the edge where out_valid && out_ready.
- Simultaneous take and accept: when out_ready = 1 with a full pipeline, the result is taken and a new operation is accepted on the same edge, with no bubble.
- Critical path per stage: one BLOCK-bit slice (BLOCK/4 groups in ripple) plus the stage mux.
- No combinational path from a/b to any output. in_ready depends combinationally only on out_valid and out_ready.

## Test plan
All scenarios use WIDTH=64, BLOCK=16.
- Reset, then idle:
  - out_valid = 0, in_ready = 1, all outputs 0.
- Back-to-back adds with out_ready = 1, accepted on consecutive edges (cin=0 unless stated):
  - A = 0xFFFF_FFFF_FFFF_FFFF, B = 0x1 -> sum = 0, cout = 1, zero = 1, ovf = 0, 4 cycles after accept.
  - A = 0x7FFF_FFFF_FFFF_FFFF, B = 1 -> sum = 0x8000_0000_0000_0000, ovf = 1, cout = 0, on the next cycle.
- Subtract:
  - A = 5, B = 7, op_sub = 1 -> sum = 0xFFFF_FFFF_FFFF_FFFE, cout = 0.
  - A = 7, B = 5, cin = 1 (ignored) -> sum = 2, cout = 1.
- Carry crossing every stage boundary:
  - A = 0x0000_FFFF_FFFF_FFFF, B = 0, cin = 1 -> sum = 0x0001_0000_0000_0000.
- Backpressure:
  - Issue 6 operations with tags 0..5 and hold out_ready = 0 for 3 cycles after the first result.
  - Required: in_ready = 0 and the result is held stable during the stall; results then emerge in tag order 0..5 with none lost or duplicated.
- Reset mid-flight:
  - Assert rst for 1 cycle with 3 operations in flight -> no out_valid for them; next accepted operation appears 4 cycles later with correct sum.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor.
// WIDTH is resolved BLOCK bits per registered stage; inside a slice the bits
// are grouped into 4-bit look-ahead groups that ripple into one another.
// Slice 0 is resolved while the operation is captured, so an operation
// accepted on edge N is presented after edge N+STAGES-1.
// The whole pipeline advances together whenever the output is free or taken.
module pipelined_cla_adder #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  localparam int STAGES = WIDTH / BLOCK;

  generate
    if ((WIDTH % BLOCK) != 0 || (BLOCK % 4) != 0 || BLOCK < 4) begin : g_param_check
      $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK, BLOCK a multiple of 4");
    end
  endgenerate

  // One BLOCK-bit slice: 4-bit look-ahead groups, rippling group to group.
  // Returns {carry_out, slice_sum}.
  function automatic logic [BLOCK:0] cla_slice(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic             c0);
    logic [BLOCK-1:0] s;
    logic [3:0]       p;
    logic [3:0]       g;
    logic [4:0]       gc;
    logic             c;
    s = '0;
    c = c0;
    for (int j = 0; j < BLOCK / 4; j++) begin
      p     = x[4*j +: 4] ^ y[4*j +: 4];
      g     = x[4*j +: 4] & y[4*j +: 4];
      gc[0] = c;
      gc[1] = g[0] | (p[0] & c);
      gc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      gc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      gc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c);
      s[4*j +: 4] = p ^ gc[3:0];
      c = gc[4];
    end
    return {c, s};
  endfunction

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [TAG_W-1:0] tag_q [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [TAG_W-1:0] tag_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic ovf_q, ovf_d, zero_q, zero_d;
  logic adv;

  logic [WIDTH-1:0] src_a, src_b, src_sum;
  logic [TAG_W-1:0] src_tag;
  logic             src_c, src_v;
  logic [BLOCK:0]   res;

  assign adv      = !valid_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  // Per-stage next state: resolve slice k on top of whatever stage k-1 holds.
  always_comb begin
    src_a   = '0;
    src_b   = '0;
    src_sum = '0;
    src_tag = '0;
    src_c   = 1'b0;
    src_v   = 1'b0;
    res     = '0;
    ovf_d   = 1'b0;
    zero_d  = 1'b0;
    c_d     = '0;
    valid_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = '0;
      b_d[k]   = '0;
      sum_d[k] = '0;
      tag_d[k] = '0;
    end
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src_a   = a;
        src_b   = op_sub ? ~b : b;
        src_c   = op_sub ? 1'b1 : cin;
        src_sum = '0;
        src_tag = tag_in;
        src_v   = in_valid;
      end else begin
        src_a   = a_q[(k == 0) ? 0 : k - 1];
        src_b   = b_q[(k == 0) ? 0 : k - 1];
        src_c   = c_q[(k == 0) ? 0 : k - 1];
        src_sum = sum_q[(k == 0) ? 0 : k - 1];
        src_tag = tag_q[(k == 0) ? 0 : k - 1];
        src_v   = valid_q[(k == 0) ? 0 : k - 1];
      end
      res                         = cla_slice(src_a[k*BLOCK +: BLOCK], src_b[k*BLOCK +: BLOCK], src_c);
      sum_d[k]                    = src_sum;
      sum_d[k][k*BLOCK +: BLOCK]  = res[BLOCK-1:0];
      c_d[k]                      = res[BLOCK];
      a_d[k]                      = src_a;
      b_d[k]                      = src_b;
      tag_d[k]                    = src_tag;
      valid_d[k]                  = src_v;
      if (k == STAGES - 1) begin
        ovf_d  = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum_d[k][WIDTH-1] != src_a[WIDTH-1]);
        zero_d = ~|sum_d[k];
      end
    end
  end

  // Stage registers; data only loads behind a valid op so bubbles leave results untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        if (valid_d[k]) begin
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          sum_q[k] <= sum_d[k];
          tag_q[k] <= tag_d[k];
          c_q[k]   <= c_d[k];
        end
      end
      if (valid_d[STAGES-1]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign tag_out   = tag_q[STAGES-1];

endmodule
